// File: rtl/imultiplier_pkg.sv
// Shared types for the multicycle integer multiplier.
//   mul_state_e : control state of the shift-add sequencer
package imultiplier_pkg;

  typedef enum logic {
    MUL_IDLE = 1'b0,
    MUL_BUSY = 1'b1
  } mul_state_e;

endpackage

// File: rtl/imultiplier.sv
// Multicycle signed/unsigned integer multiplier, radix-2 shift-add, one
// multiplier bit per cycle. Produces the full 2*DATA_WIDTH product.
// Ports:
//   clk        : clock, all state on rising edge
//   rst_n      : asynchronous active-low reset
//   a          : multiplicand, captured into the operand register on write_a
//   b          : multiplier, sampled on the start edge
//   signed_ope : 1 = both operands two's complement, 0 = both unsigned
//   write_a    : load a into the operand register
//   start      : level; a rising edge begins an operation
//   flush      : abort the current operation
//   product_lo : low word of the product
//   product_hi : high word of the product
//   ready      : 1 = idle and product valid
module imultiplier
  import imultiplier_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic                  signed_ope,
  input  logic                  write_a,
  input  logic                  start,
  input  logic                  flush,
  output logic [DATA_WIDTH-1:0] product_lo,
  output logic [DATA_WIDTH-1:0] product_hi,
  output logic                  ready
);

  localparam int COUNT_WIDTH = $clog2(DATA_WIDTH + 1);
  localparam logic [COUNT_WIDTH-1:0] LAST_COUNT = COUNT_WIDTH'(DATA_WIDTH - 1);

  logic [DATA_WIDTH-1:0]   opa;
  logic [DATA_WIDTH-1:0]   mag_a;
  logic [DATA_WIDTH:0]     acc_hi;
  logic [DATA_WIDTH-1:0]   acc_lo;
  logic                    neg_flag;
  logic [COUNT_WIDTH-1:0]  count;
  logic                    start_prev;
  mul_state_e              state;

  logic                    start_edge;
  logic                    a_neg;
  logic                    b_neg;
  logic [DATA_WIDTH-1:0]   a_abs;
  logic [DATA_WIDTH-1:0]   b_abs;
  logic [DATA_WIDTH:0]     sum;
  logic [2*DATA_WIDTH-1:0] prod_mag;
  logic [2*DATA_WIDTH-1:0] prod;

  // Operand register: independent of start, so a same-cycle write_a only
  // takes effect for the next operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opa <= '0;
    end else if (write_a) begin
      opa <= a;
    end
  end

  always_comb begin
    start_edge = start & ~start_prev;
    a_neg      = signed_ope & opa[DATA_WIDTH-1];
    b_neg      = signed_ope & b[DATA_WIDTH-1];
    // Negating the most negative value yields itself, which read as
    // unsigned is the correct magnitude.
    a_abs      = a_neg ? -opa : opa;
    b_abs      = b_neg ? -b : b;
    sum        = acc_lo[0] ? (acc_hi + {1'b0, mag_a}) : acc_hi;
    prod_mag   = {acc_hi[DATA_WIDTH-1:0], acc_lo};
    prod       = neg_flag ? -prod_mag : prod_mag;
  end

  assign product_hi = prod[2*DATA_WIDTH-1:DATA_WIDTH];
  assign product_lo = prod[DATA_WIDTH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= MUL_IDLE;
      ready      <= 1'b1;
      mag_a      <= '0;
      acc_hi     <= '0;
      acc_lo     <= '0;
      neg_flag   <= 1'b0;
      count      <= '0;
      start_prev <= 1'b0;
    end else begin
      start_prev <= start;
      if (flush) begin
        // Accumulator is left as is; the edge on start, if any, is consumed.
        state <= MUL_IDLE;
        ready <= 1'b1;
        count <= '0;
      end else if (start_edge) begin
        state    <= MUL_BUSY;
        ready    <= 1'b0;
        mag_a    <= a_abs;
        acc_hi   <= '0;
        acc_lo   <= b_abs;
        // A zero product is never reported as negative.
        neg_flag <= (a_neg ^ b_neg) && (a_abs != '0) && (b_abs != '0);
        count    <= '0;
      end else if (state == MUL_BUSY) begin
        // Shift the (W+1)-bit sum and the low word right as one register,
        // so the adder carry lands in the top bit of hi.
        acc_hi <= {1'b0, sum[DATA_WIDTH:1]};
        acc_lo <= {sum[0], acc_lo[DATA_WIDTH-1:1]};
        count  <= count + 1'b1;
        if (count == LAST_COUNT) begin
          state <= MUL_IDLE;
          ready <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_imultiplier.sv
// Self-checking bench for imultiplier: table of directed vectors plus
// hand-written handshake, flush and reset sequences.
module tb_imultiplier;

  logic        clk;
  logic        rst_n;
  logic [31:0] a;
  logic [31:0] b;
  logic        signed_ope;
  logic        write_a;
  logic        start;
  logic        flush;
  logic [31:0] product_lo;
  logic [31:0] product_hi;
  logic        ready;

  int checks;
  int failures;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sgn;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  vec_t vecs[8];

  imultiplier #(.DATA_WIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .a          (a),
    .b          (b),
    .signed_ope (signed_ope),
    .write_a    (write_a),
    .start      (start),
    .flush      (flush),
    .product_lo (product_lo),
    .product_hi (product_hi),
    .ready      (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Load a, raise start, count busy cycles (bounded) and check the result.
  task automatic run_op(input string name, input logic [31:0] va, input logic [31:0] vb,
                        input logic sgn, input logic [31:0] eh, input logic [31:0] el);
    int n;
    @(posedge clk); #1;
    a = va; write_a = 1'b1; start = 1'b0;
    @(posedge clk); #1;
    write_a = 1'b0; b = vb; signed_ope = sgn; start = 1'b1;
    @(posedge clk); #1;
    check({name, " ready_low"}, 64'(ready), 64'd0);
    start = 1'b0;
    n = 0;
    while (n < 40) begin
      @(posedge clk); #1;
      n++;
      if (ready) break;
    end
    check({name, " latency"}, 64'(n), 64'd32);
    check({name, " product"}, {product_hi, product_lo}, {eh, el});
  endtask

  initial begin
    int n;
    logic stayed;
    checks = 0; failures = 0;
    rst_n = 1'b0; a = '0; b = '0; signed_ope = 1'b0;
    write_a = 1'b0; start = 1'b0; flush = 1'b0;

    vecs[0] = '{32'd7,        32'd6,        1'b0, 32'h00000000, 32'h0000002A};
    vecs[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFE, 32'h00000001};
    vecs[2] = '{32'hFFFFFFFD, 32'd5,        1'b1, 32'hFFFFFFFF, 32'hFFFFFFF1};
    vecs[3] = '{32'h80000000, 32'h80000000, 1'b1, 32'h40000000, 32'h00000000};
    vecs[4] = '{32'h80000000, 32'd1,        1'b1, 32'hFFFFFFFF, 32'h80000000};
    vecs[5] = '{32'hFFFFFFFD, 32'd5,        1'b0, 32'h00000004, 32'hFFFFFFF1};
    vecs[6] = '{32'd7,        32'hFFFFFFFA, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFD6};
    vecs[7] = '{32'd0,        32'hFFFFFFFB, 1'b1, 32'h00000000, 32'h00000000};

    repeat (2) @(posedge clk);
    #1;
    check("reset ready", 64'(ready), 64'd1);
    check("reset product", {product_hi, product_lo}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].sgn,
             vecs[i].exp_hi, vecs[i].exp_lo);
    end

    // Flush after ten busy cycles.
    @(posedge clk); #1;
    a = 32'd9; write_a = 1'b1;
    @(posedge clk); #1;
    write_a = 1'b0; b = 32'd9; signed_ope = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("flush busy", 64'(ready), 64'd0);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush ready", 64'(ready), 64'd1);
    @(posedge clk); #1;
    check("flush stays idle", 64'(ready), 64'd1);

    // Flush coinciding with a start edge consumes the edge.
    start = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(posedge clk); #1;
    check("flush eats start", 64'(ready), 64'd1);
    start = 1'b0;

    // start held high for 40 cycles runs exactly one operation.
    @(posedge clk); #1;
    a = 32'd3; write_a = 1'b1;
    @(posedge clk); #1;
    write_a = 1'b0; b = 32'd4; start = 1'b1;
    @(posedge clk); #1;
    n = 0;
    while (n < 40 && !ready) begin
      @(posedge clk); #1;
      n++;
    end
    check("held latency", 64'(n), 64'd32);
    check("held product", {product_hi, product_lo}, 64'd12);
    stayed = 1'b1;
    repeat (7) begin
      @(posedge clk); #1;
      if (!ready) stayed = 1'b0;
    end
    check("held no restart", 64'(stayed), 64'd1);
    start = 1'b0;

    run_op("12x12", 32'd12, 32'd12, 1'b0, 32'd0, 32'd144);

    // Restart while busy: the second start edge wins.
    @(posedge clk); #1;
    a = 32'd100; write_a = 1'b1;
    @(posedge clk); #1;
    write_a = 1'b0; b = 32'd50; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    b = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (n < 40 && !ready) begin
      @(posedge clk); #1;
      n++;
    end
    check("restart latency", 64'(n), 64'd32);
    check("restart product", {product_hi, product_lo}, 64'd300);

    // Asynchronous reset mid-operation.
    @(posedge clk); #1;
    a = 32'hFFFFFFFF; write_a = 1'b1;
    @(posedge clk); #1;
    write_a = 1'b0; b = 32'h12345678; signed_ope = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async rst ready", 64'(ready), 64'd1);
    check("async rst product", {product_hi, product_lo}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("post reset", 32'hFFFFFFFF, 32'd2, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
